audacq_fifo: RTL and testbench

//  Sample buffer downstream of the audio acquisition path: captures every (din_vld, din) sample
//  (raw/truncated or demodulated) into a FIFO so software can drain at bus speed without losing samples.
//  Bus-mapped slave on the peripheral bus; drops and counts samples on overflow; optional level IRQ.

---
 rtl/audacq_fifo.sv | 167 ++++++++++++++++
 tb/tb_audacq_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/audacq_fifo.sv
// Audio sample FIFO with a bus-mapped register interface (DR pop, SR status, CR control).
// Define AUDFIFO_IRQ_EN to build the registered level-threshold interrupt; otherwise irq is tied low.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module audacq_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                addr,
    input  logic                      w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     rdata,
    input  logic [`BUS_WIDTH-1:0]     wdata,
    input  logic                      req,
    output logic                      resp,
    output logic                      fault,
    input  logic                      din_vld,
    input  logic [15:0]               din,
    output logic                      irq
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = LW - 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [15:0]           mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic [`BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;

    logic illegal, legal;
    logic rd_dr, rd_sr, wr_cr, flush;
    logic empty, full;
    logic push, pop, drop;

    always_comb begin
        illegal = (addr[1:0] != 2'b00) || (acc != `BUS_ACC_4B) || (addr > 4'd8)
               || (w_rb && (addr != 4'd8)) || (!w_rb && (addr == 4'd8));
        legal   = req && !illegal;
        fault   = req && illegal;
        rd_dr   = legal && !w_rb && (addr == 4'd0);
        rd_sr   = legal && !w_rb && (addr == 4'd4);
        wr_cr   = legal && w_rb;
        flush   = wr_cr && wdata[31];
    end

    // A pop frees a slot this cycle, so a full FIFO still accepts a coincident sample.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);
        pop   = rd_dr && !empty && !flush;
        push  = din_vld && (!full || pop) && !flush;
        drop  = din_vld && full && !pop && !flush;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        rdata_d  = rdata_q;
        resp_d   = legal;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        // Status read clears first so a coincident drop lands on top of the cleared value.
        if (rd_sr) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = (drop_d == 8'hFF) ? 8'hFF : drop_d + 8'd1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = 8'd0;
        end

        if (rd_dr)
            rdata_d = empty ? '0 : {1'b1, 15'd0, mem_q[rd_ptr_q]};
        else if (rd_sr)
            rdata_d = {ovf_q, 7'd0, drop_q, 16'(level_q)};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
        end
    end

    // NOTE: sample storage has no reset; entries are only visible between the pointers, which are reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign rdata = rdata_q;
    assign resp  = resp_q;

`ifdef AUDFIFO_IRQ_EN
    logic [LW-1:0] thresh_q, thresh_d;
    logic          irq_q, irq_d;
    logic          unused_wdata;

    always_comb begin
        thresh_d = wr_cr ? wdata[LW-1:0] : thresh_q;
        irq_d    = (thresh_q != '0) && (level_q >= thresh_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign irq          = irq_q;
    assign unused_wdata = ^wdata[`BUS_WIDTH-2:LW];
`else
    logic unused_wdata;

    assign irq          = 1'b0;
    assign unused_wdata = ^wdata[`BUS_WIDTH-2:0];
`endif

endmodule

// File: tb/tb_audacq_fifo.sv
// Directed bench for audacq_fifo: register access, overflow/drop accounting, flush, faults and irq.
// Expected irq values follow the AUDFIFO_IRQ_EN setting of the build.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_audacq_fifo;

    localparam int DEPTH = 64;
    localparam logic [1:0] ACC4 = `BUS_ACC_4B;
    localparam logic [1:0] ACC2 = 2'd1;
`ifdef AUDFIFO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [3:0]                addr = '0;
    logic                      w_rb = 1'b0;
    logic [`BUS_ACC_WIDTH-1:0] acc = ACC4;
    logic [`BUS_WIDTH-1:0]     rdata;
    logic [`BUS_WIDTH-1:0]     wdata = '0;
    logic                      req = 1'b0;
    logic                      resp;
    logic                      fault;
    logic                      din_vld = 1'b0;
    logic [15:0]               din = '0;
    logic                      irq;

    int n_cmp = 0;
    int n_err = 0;

    audacq_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc), .rdata(rdata),
        .wdata(wdata), .req(req), .resp(resp), .fault(fault), .din_vld(din_vld),
        .din(din), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access (optionally with a coincident sample); fault sampled mid-cycle, resp/rdata one cycle later.
    task automatic bus(input logic wr, input logic [3:0] a, input logic [1:0] ac, input logic [31:0] wd,
                       input logic vld, input logic [15:0] d,
                       output logic flt, output logic rsp, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; w_rb = wr; addr = a; acc = ac; wdata = wd; din_vld = vld; din = d;
        #1 flt = fault;
        @(negedge clk);
        req = 1'b0; din_vld = 1'b0;
        rsp = resp;
        rd  = rdata;
    endtask

    task automatic acc_chk(input string tag, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                           input logic vld, input logic [15:0] d, input logic [31:0] exp);
        logic f, r;
        logic [31:0] rd;
        bus(wr, a, ACC4, wd, vld, d, f, r, rd);
        check({tag, "_fault"}, {31'd0, f}, 32'd0);
        check({tag, "_resp"}, {31'd0, r}, 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic bad_chk(input string tag, input logic wr, input logic [3:0] a, input logic [1:0] ac);
        logic f, r;
        logic [31:0] rd;
        bus(wr, a, ac, 32'h8000_0000, 1'b0, 16'h0, f, r, rd);
        check({tag, "_fault"}, {31'd0, f}, 32'd1);
        check({tag, "_resp"}, {31'd0, r}, 32'd0);
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        din_vld = 1'b1; din = d;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {31'd0, resp}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        acc_chk("rst_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0000);

        push(16'h1234); push(16'h8000); push(16'h7FFF);
        acc_chk("dr0", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_1234);
        acc_chk("dr1", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_8000);
        acc_chk("dr2", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_7FFF);
        acc_chk("dr_empty", 1'b0, 4'd0, 0, 1'b0, 0, 32'h0000_0000);

        for (int i = 0; i < DEPTH + 5; i++) push(16'h0100 + 16'(i));
        acc_chk("sr_ovf", 1'b0, 4'd4, 0, 1'b0, 0, 32'h8005_0040);
        acc_chk("sr_clr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0040);

        acc_chk("full_pop_push", 1'b0, 4'd0, 0, 1'b1, 16'hAAAA, 32'h8000_0100);
        acc_chk("full_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0040);

        bad_chk("bad_a2", 1'b0, 4'd2, ACC4);
        bad_chk("bad_2b", 1'b0, 4'd0, ACC2);
        bad_chk("bad_wdr", 1'b1, 4'd0, ACC4);
        bad_chk("bad_rcr", 1'b0, 4'd8, ACC4);
        check("bad_hold", rdata, 32'h0000_0040);
        acc_chk("bad_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0040);

        acc_chk("sr_drop_pre", 1'b0, 4'd4, 0, 1'b1, 16'hBBBB, 32'h0000_0040);
        acc_chk("sr_drop_post", 1'b0, 4'd4, 0, 1'b0, 0, 32'h8001_0040);
        acc_chk("dr_head", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_0101);

        acc_chk("cr_flush", 1'b1, 4'd8, 32'h8000_0000, 1'b0, 0, 32'h8000_0101);
        acc_chk("flush_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0000);
        for (int i = 0; i < 10; i++) push(16'h0200 + 16'(i));
        acc_chk("ten_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_000A);
        acc_chk("flush_vld", 1'b1, 4'd8, 32'h8000_0000, 1'b1, 16'hCCCC, 32'h0000_000A);
        acc_chk("flush_vld_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0000);
        acc_chk("flush_vld_dr", 1'b0, 4'd0, 0, 1'b0, 0, 32'h0000_0000);

        acc_chk("empty_pop_push", 1'b0, 4'd0, 0, 1'b1, 16'h5555, 32'h0000_0000);
        acc_chk("epp_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0001);
        acc_chk("epp_dr", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_5555);

        acc_chk("cr_th4", 1'b1, 4'd8, 32'h0000_0004, 1'b0, 0, 32'h8000_5555);
        for (int i = 0; i < 3; i++) push(16'hA000 + 16'(i));
        @(negedge clk);
        check("irq_lvl3", {31'd0, irq}, 32'd0);
        push(16'hA003);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_lvl4", {31'd0, irq}, {31'd0, IRQ_ON});
        acc_chk("irq_pop", 1'b0, 4'd0, 0, 1'b0, 0, 32'h8000_A000);
        @(negedge clk);
        check("irq_after_pop", {31'd0, irq}, 32'd0);
        push(16'hA004);
        @(negedge clk);
        check("irq_relvl4", {31'd0, irq}, {31'd0, IRQ_ON});
        acc_chk("cr_th0", 1'b1, 4'd8, 32'h0000_0000, 1'b0, 0, 32'h8000_A000);
        @(negedge clk);
        check("irq_th0", {31'd0, irq}, 32'd0);
        acc_chk("th0_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0004);

        @(negedge clk);
        req = 1'b1; w_rb = 1'b0; addr = 4'd0; acc = ACC4; rst = 1'b1;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        check("rst_mid_resp", {31'd0, resp}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        acc_chk("rst_mid_sr", 1'b0, 4'd4, 0, 1'b0, 0, 32'h0000_0000);
        acc_chk("rst_mid_dr", 1'b0, 4'd0, 0, 1'b0, 0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
